// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: width defaults and the
// data-memory interface FSM state encoding.
package mem_stage_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int IMM8_WIDTH_DEF = 8;
  localparam int REG_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  // Handshake: req rises to start an access and, together with we, addr and
  // wdata, stays stable until ack is seen high at a rising clock edge. rdata is
  // valid in the ack cycle only. ack outside a pending request is ignored.
  logic                  dmem_req_o;
  logic                  dmem_we_o;
  logic [ADDR_WIDTH-1:0] dmem_addr_o;
  logic [DATA_WIDTH-1:0] dmem_wdata_o;
  logic                  dmem_ack_i;
  logic [DATA_WIDTH-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );

endinterface

// File: rtl/mem_stage_dmem_if_fsm.sv
// Data-memory access sequencer: issues the registered request, waits for
// ack, buffers read data and raises the stall while the access is pending.
module dmem_if_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_op_i,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  req_o,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_buf_o,
  output mem_state_e            state_o
);

  mem_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_buf_q, rdata_buf_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      rdata_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rdata_buf_d = rdata_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_i) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack_i) begin
          state_d     = ST_DONE;
          req_d       = 1'b0;
          rdata_buf_d = rdata_i;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Stall is combinational so the hazard unit freezes EX/MEM in the very
  // cycle the memory op arrives.
  always_comb begin
    req_o       = req_q;
    stall_o     = mem_op_i & (state_q != ST_DONE);
    rdata_buf_o = rdata_buf_q;
    state_o     = state_q;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-memory access, branch resolution, M-stage forwarding
// value and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int IMM8_WIDTH = IMM8_WIDTH_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCM_i,
  input  logic [IMM8_WIDTH-1:0] imm8M_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MemToRegM_i,
  input  logic                  MovM_i,
  input  logic                  flush_MEM_WB_i,
  input  logic                  stall_MEM_WB_i,
  mem_stage_if.master           dmem,
  output logic                  stall_mem_o,
  output logic                  branch_taken_o,
  output logic [ADDR_WIDTH-1:0] branch_target_o,
  output logic [DATA_WIDTH-1:0] WBResultM_o,
  output logic [DATA_WIDTH-1:0] ResultW_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic                  RegWriteW_o,
  output mem_state_e            state_dbg_o
);

  logic                  mem_op;
  logic                  req;
  logic [DATA_WIDTH-1:0] rdata_buf;
  logic [DATA_WIDTH-1:0] final_result;
  logic [ADDR_WIDTH-1:0] imm_sx;

  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [REG_WIDTH-1:0]  wreg_q, wreg_d;
  logic                  regwrite_q, regwrite_d;

  assign mem_op = MemReadM_i | MemWriteM_i;

  dmem_if_fsm #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_dmem_if_fsm (
    .clk         (clk),
    .rst         (rst),
    .mem_op_i    (mem_op),
    .ack_i       (dmem.dmem_ack_i),
    .rdata_i     (dmem.dmem_rdata_i),
    .req_o       (req),
    .stall_o     (stall_mem_o),
    .rdata_buf_o (rdata_buf),
    .state_o     (state_dbg_o)
  );

  // Address and write data come straight from EX/MEM, which the hazard unit
  // holds for the whole access.
  assign dmem.dmem_req_o   = req;
  assign dmem.dmem_we_o    = MemWriteM_i;
  assign dmem.dmem_addr_o  = alu_outM_i[ADDR_WIDTH-1:0];
  assign dmem.dmem_wdata_o = WriteDataM_i;

  assign WBResultM_o = MovM_i ? {{(DATA_WIDTH-IMM8_WIDTH){1'b0}}, imm8M_i} : alu_outM_i;

  // In DONE the ack cycle has passed, so read data comes from the buffer.
  assign final_result = MemToRegM_i
                      ? ((state_dbg_o == ST_DONE) ? rdata_buf : dmem.dmem_rdata_i)
                      : WBResultM_o;

  assign imm_sx          = ADDR_WIDTH'($signed(imm8M_i));
  assign branch_taken_o  = BranchM_i & (alu_outM_i == '0);
  assign branch_target_o = PCM_i + imm_sx;

  always_comb begin
    result_d   = result_q;
    wreg_d     = wreg_q;
    regwrite_d = regwrite_q;
    if (flush_MEM_WB_i) begin
      result_d   = '0;
      wreg_d     = '0;
      regwrite_d = 1'b0;
    end else if (stall_MEM_WB_i) begin
      result_d   = result_q;
      wreg_d     = wreg_q;
      regwrite_d = regwrite_q;
    end else if (stall_mem_o) begin
      result_d   = '0;
      wreg_d     = '0;
      regwrite_d = 1'b0;
    end else begin
      result_d   = final_result;
      wreg_d     = WriteRegM_i;
      regwrite_d = RegWriteM_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q   <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      wreg_q     <= wreg_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign ResultW_o   = result_q;
  assign WriteRegW_o = wreg_q;
  assign RegWriteW_o = regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a scoreboard of expected MEM/WB words,
// a latency-controlled memory responder and directed/random scenarios.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  PCM_i;
  logic [7:0]  imm8M_i;
  logic [3:0]  WriteRegM_i;
  logic [15:0] alu_outM_i;
  logic [15:0] WriteDataM_i;
  logic        RegWriteM_i, BranchM_i, MemReadM_i, MemWriteM_i, MemToRegM_i, MovM_i;
  logic        flush_MEM_WB_i, stall_MEM_WB_i;
  logic        stall_mem_o, branch_taken_o;
  logic [7:0]  branch_target_o;
  logic [15:0] WBResultM_o, ResultW_o;
  logic [3:0]  WriteRegW_o;
  logic        RegWriteW_o;
  mem_state_e  state_dbg_o;

  mem_stage_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dmem_bus ();

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .PCM_i           (PCM_i),
    .imm8M_i         (imm8M_i),
    .WriteRegM_i     (WriteRegM_i),
    .alu_outM_i      (alu_outM_i),
    .WriteDataM_i    (WriteDataM_i),
    .RegWriteM_i     (RegWriteM_i),
    .BranchM_i       (BranchM_i),
    .MemReadM_i      (MemReadM_i),
    .MemWriteM_i     (MemWriteM_i),
    .MemToRegM_i     (MemToRegM_i),
    .MovM_i          (MovM_i),
    .flush_MEM_WB_i  (flush_MEM_WB_i),
    .stall_MEM_WB_i  (stall_MEM_WB_i),
    .dmem            (dmem_bus),
    .stall_mem_o     (stall_mem_o),
    .branch_taken_o  (branch_taken_o),
    .branch_target_o (branch_target_o),
    .WBResultM_o     (WBResultM_o),
    .ResultW_o       (ResultW_o),
    .WriteRegW_o     (WriteRegW_o),
    .RegWriteW_o     (RegWriteW_o),
    .state_dbg_o     (state_dbg_o)
  );

  // Expected MEM/WB word: {RegWriteW, WriteRegW, ResultW}
  logic [20:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_nop();
    PCM_i        = '0;
    imm8M_i      = '0;
    WriteRegM_i  = '0;
    alu_outM_i   = '0;
    WriteDataM_i = '0;
    RegWriteM_i  = 1'b0;
    BranchM_i    = 1'b0;
    MemReadM_i   = 1'b0;
    MemWriteM_i  = 1'b0;
    MemToRegM_i  = 1'b0;
    MovM_i       = 1'b0;
  endtask

  task automatic sb_check(input string name);
    logic [20:0] exp;
    logic [20:0] got;
    got = {RegWriteW_o, WriteRegW_o, ResultW_o};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL %s: memwb got %h expected %h", name, got, exp);
      end
    end
  endtask

  // Drives one instruction at a negedge, plays the memory for `lat` request
  // cycles, counts stall cycles and checks the MEM/WB capture.
  task automatic run_instr(input logic [15:0] alu, input logic [15:0] wd,
                           input logic [7:0] imm, input logic [3:0] wreg,
                           input logic rw, input logic mr, input logic mw,
                           input logic m2r, input logic mov,
                           input int lat, input logic [15:0] rd,
                           input int exp_stall, input string name,
                           output logic [7:0] seen_addr, output logic seen_we,
                           output logic [15:0] seen_wdata);
    int cnt;
    int nstall;
    bit done;
    bit seen;
    logic [15:0] exp_wb;
    logic [15:0] exp_res;
    alu_outM_i   = alu;
    WriteDataM_i = wd;
    imm8M_i      = imm;
    WriteRegM_i  = wreg;
    RegWriteM_i  = rw;
    MemReadM_i   = mr;
    MemWriteM_i  = mw;
    MemToRegM_i  = m2r;
    MovM_i       = mov;
    exp_wb  = mov ? {8'h00, imm} : alu;
    exp_res = m2r ? rd : exp_wb;
    exp_q.push_back({rw, wreg, exp_res});
    cnt = 0; nstall = 0; done = 1'b0; seen = 1'b0;
    seen_addr = '0; seen_we = 1'b0; seen_wdata = '0;
    #1;
    checks++;
    if (WBResultM_o !== exp_wb) begin
      failures++;
      $display("FAIL %s_wbresult: got %h expected %h", name, WBResultM_o, exp_wb);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      if (!stall_mem_o) done = 1'b1;
      else begin
        nstall++;
        if (dmem_bus.dmem_req_o) begin
          if (!seen) begin
            seen       = 1'b1;
            seen_addr  = dmem_bus.dmem_addr_o;
            seen_we    = dmem_bus.dmem_we_o;
            seen_wdata = dmem_bus.dmem_wdata_o;
          end
          cnt++;
          if (cnt >= lat) begin
            dmem_bus.dmem_ack_i   = 1'b1;
            dmem_bus.dmem_rdata_i = rd;
          end
        end
        @(negedge clk);
        dmem_bus.dmem_ack_i   = 1'b0;
        dmem_bus.dmem_rdata_i = 16'hDEAD;
        #1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: stall still high after %0d cycles", name, nstall);
    end else if (nstall != exp_stall) begin
      failures++;
      $display("FAIL %s_stall_cycles: got %0d expected %0d", name, nstall, exp_stall);
    end
    @(posedge clk);
    #1;
    sb_check(name);
    @(negedge clk);
    drive_nop();
  endtask

  task automatic test_reset();
    checks++;
    if ({dmem_bus.dmem_req_o, ResultW_o, WriteRegW_o, RegWriteW_o} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b res=%h reg=%h rw=%b expected zeros",
               dmem_bus.dmem_req_o, ResultW_o, WriteRegW_o, RegWriteW_o);
    end
    checks++;
    if (state_dbg_o !== ST_IDLE || stall_mem_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d stall=%b expected 0/0", state_dbg_o, stall_mem_o);
    end
  endtask

  task automatic test_alu();
    logic [7:0] a; logic w; logic [15:0] d;
    run_instr(16'h1234, 16'h0, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              0, 16'h0, 0, "alu", a, w, d);
  endtask

  task automatic test_load();
    logic [7:0] a; logic w; logic [15:0] d;
    run_instr(16'h0040, 16'h0, 8'h00, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
              3, 16'hBEEF, 4, "load", a, w, d);
    checks++;
    if (a !== 8'h40 || w !== 1'b0) begin
      failures++;
      $display("FAIL load_bus: got addr=%h we=%b expected 40/0", a, w);
    end
  endtask

  task automatic test_store();
    logic [7:0] a; logic w; logic [15:0] d;
    run_instr(16'h0021, 16'h00AA, 8'h00, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              1, 16'h0, 2, "store", a, w, d);
    checks++;
    if (a !== 8'h21 || w !== 1'b1 || d !== 16'h00AA) begin
      failures++;
      $display("FAIL store_bus: got addr=%h we=%b wdata=%h expected 21/1/00aa", a, w, d);
    end
  endtask

  task automatic test_branch();
    logic [7:0] pc;
    logic [7:0] imm;
    logic [15:0] alu;
    logic [7:0] exp_t;
    logic exp_tk;
    @(negedge clk);
    BranchM_i = 1'b1; alu_outM_i = 16'h0000; PCM_i = 8'h02; imm8M_i = 8'hFC;
    #1;
    checks++;
    if (branch_taken_o !== 1'b1 || branch_target_o !== 8'hFE) begin
      failures++;
      $display("FAIL branch_wrap: got taken=%b target=%h expected 1/fe", branch_taken_o, branch_target_o);
    end
    alu_outM_i = 16'h0005;
    #1;
    checks++;
    if (branch_taken_o !== 1'b0) begin
      failures++;
      $display("FAIL branch_not_taken: got %b expected 0", branch_taken_o);
    end
    for (int i = 0; i < 8; i++) begin
      pc  = 8'($urandom_range(0, 255));
      imm = 8'($urandom_range(0, 255));
      alu = ($urandom_range(0, 1) == 1) ? 16'h0000 : 16'($urandom_range(1, 65535));
      BranchM_i  = 1'($urandom_range(0, 1));
      PCM_i = pc; imm8M_i = imm; alu_outM_i = alu;
      exp_t  = 8'(((int'(pc) + int'($signed(imm))) % 256 + 256) % 256);
      exp_tk = BranchM_i && (alu == 16'h0000);
      #1;
      checks++;
      if (branch_taken_o !== exp_tk || branch_target_o !== exp_t) begin
        failures++;
        $display("FAIL branch_rand%0d: got taken=%b target=%h expected %b/%h",
                 i, branch_taken_o, branch_target_o, exp_tk, exp_t);
      end
    end
    @(negedge clk);
    drive_nop();
    @(posedge clk);
    #1;
    exp_q.push_back(21'd0);
    sb_check("branch_drain");
    @(negedge clk);
  endtask

  task automatic test_mov();
    logic [7:0] a; logic w; logic [15:0] d;
    run_instr(16'h9999, 16'h0, 8'h7F, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
              0, 16'h0, 0, "mov", a, w, d);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a; logic w; logic [15:0] d;
    int lat;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 2) begin
        lat = $urandom_range(1, 4);
        run_instr(16'($urandom_range(0, 65535)), 16'h0, 8'h00, 4'($urandom_range(0, 15)),
                  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, lat, 16'($urandom_range(0, 65535)),
                  lat + 1, "b2b_load", a, w, d);
      end else begin
        run_instr(16'($urandom_range(0, 65535)), 16'h0, 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0,
                  1'($urandom_range(0, 1)), 0, 16'h0, 0, "b2b_alu", a, w, d);
      end
    end
  endtask

  task automatic test_memwb_ctrl();
    logic [7:0] a; logic w; logic [15:0] d;
    run_instr(16'hAAAA, 16'h0, 8'h00, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              0, 16'h0, 0, "pre_hold", a, w, d);
    alu_outM_i = 16'h5555; WriteRegM_i = 4'd2; RegWriteM_i = 1'b1;
    stall_MEM_WB_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({RegWriteW_o, WriteRegW_o, ResultW_o} !== {1'b1, 4'd7, 16'hAAAA}) begin
      failures++;
      $display("FAIL memwb_hold: got %b/%h/%h expected 1/7/aaaa", RegWriteW_o, WriteRegW_o, ResultW_o);
    end
    @(negedge clk);
    flush_MEM_WB_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({RegWriteW_o, WriteRegW_o, ResultW_o} !== 21'd0) begin
      failures++;
      $display("FAIL memwb_flush_over_stall: got %b/%h/%h expected zeros", RegWriteW_o, WriteRegW_o, ResultW_o);
    end
    @(negedge clk);
    flush_MEM_WB_i = 1'b0;
    stall_MEM_WB_i = 1'b0;
    drive_nop();
  endtask

  task automatic test_reset_mid_access();
    alu_outM_i = 16'h0033; MemReadM_i = 1'b1; MemToRegM_i = 1'b1; RegWriteM_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dmem_bus.dmem_req_o !== 1'b1 || state_dbg_o !== ST_REQ) begin
      failures++;
      $display("FAIL reset_mid_pre: got req=%b state=%0d expected 1/1", dmem_bus.dmem_req_o, state_dbg_o);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dmem_bus.dmem_req_o !== 1'b0 || state_dbg_o !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_mid_access: got req=%b state=%0d expected 0/0", dmem_bus.dmem_req_o, state_dbg_o);
    end
    drive_nop();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_flush_during_req();
    alu_outM_i = 16'h0010; MemReadM_i = 1'b1; MemToRegM_i = 1'b1;
    RegWriteM_i = 1'b1; WriteRegM_i = 4'd5;
    exp_q.push_back({1'b1, 4'd5, 16'h5A5A});
    @(posedge clk);
    @(negedge clk);
    flush_MEM_WB_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({RegWriteW_o, WriteRegW_o, ResultW_o} !== 21'd0 || dmem_bus.dmem_req_o !== 1'b1
        || state_dbg_o !== ST_REQ) begin
      failures++;
      $display("FAIL flush_in_req: got memwb=%b/%h/%h req=%b state=%0d expected zeros,1,1",
               RegWriteW_o, WriteRegW_o, ResultW_o, dmem_bus.dmem_req_o, state_dbg_o);
    end
    @(negedge clk);
    flush_MEM_WB_i = 1'b0;
    dmem_bus.dmem_ack_i   = 1'b1;
    dmem_bus.dmem_rdata_i = 16'h5A5A;
    @(posedge clk);
    #1;
    checks++;
    if (state_dbg_o !== ST_DONE || dmem_bus.dmem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_access_done: got state=%0d req=%b expected 2/0", state_dbg_o, dmem_bus.dmem_req_o);
    end
    @(negedge clk);
    dmem_bus.dmem_ack_i   = 1'b0;
    dmem_bus.dmem_rdata_i = 16'hDEAD;
    @(posedge clk);
    #1;
    sb_check("flush_then_load");
    @(negedge clk);
    drive_nop();
  endtask

  initial begin
    rst = 1'b0;
    drive_nop();
    flush_MEM_WB_i = 1'b0;
    stall_MEM_WB_i = 1'b0;
    dmem_bus.dmem_ack_i   = 1'b0;
    dmem_bus.dmem_rdata_i = 16'h0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_mov();
    test_back_to_back();
    test_memwb_ctrl();
    test_reset_mid_access();
    test_flush_during_req();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
